// File: rtl/serial_add_ctrl_if.sv
// Request/result handshake plus the bit-serial link to the shared full_adder cell.
// slave is the sequencer's view; master is the requester and adder-cell side.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin, fa_s, fa_cout,
        input  ready, busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );

    modport slave (
        input  start, sub, a, b, cin, fa_s, fa_cout,
        output ready, busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: streams operand bits LSB first through an external
// 1-bit full adder, recirculating the carry and shifting the sum bits back in.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntMsb  = CntW'(WIDTH - 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             sub_q;
    logic             carry_q;
    logic             c_msb_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        sub_q   <= bus.sub;
                        // Subtraction is a + ~b + 1, so the incoming carry is forced high.
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                        state_q <= StRun;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    carry_q <= bus.fa_cout;
                    sum_q   <= {bus.fa_s, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt_q == CntMsb) begin
                        c_msb_q <= bus.fa_cout;
                    end
                    if (cnt_q == CntLast) begin
                        cout_q  <= bus.fa_cout;
                        ovf_q   <= c_msb_q ^ bus.fa_cout;
                        state_q <= StDone;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The adder cell is shared, so its inputs are held low whenever we are not streaming.
    always_comb begin
        bus.fa_a   = 1'b0;
        bus.fa_b   = 1'b0;
        bus.fa_cin = 1'b0;
        if (state_q == StRun) begin
            bus.fa_a   = a_q[0];
            bus.fa_b   = b_q[0] ^ sub_q;
            bus.fa_cin = carry_q;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder on the fa_* link
// and an arithmetic reference model for sum, carry-out and signed overflow.
module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.fa_s    = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
    assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nbad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed interpretations.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s, output logic [7:0] es, output logic ec,
                         output logic eo);
        int r;
        int rs;
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!s) begin
            r  = int'(a) + int'(b) + int'(ci);
            rs = sa + sb + int'(ci);
            ec = (r > 255);
        end else begin
            r  = int'(a) - int'(b);
            rs = sa - sb;
            ec = (a >= b);
        end
        es = r[7:0];
        eo = (rs > 127) || (rs < -128);
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {29'd0, bus.fa_a, bus.fa_b, bus.fa_cin}, 32'd0);
    endtask

    // Issue one operation from IDLE/DONE and check latency and results; returns in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic s, input bit noise);
        logic [7:0] es;
        logic       ec;
        logic       eo;
        int         lat;
        model(a, b, ci, s, es, ec, eo);
        check_eq("ready_before", {31'd0, bus.ready}, 32'd1);
        check_quiet("fa_quiet_before");
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.sub   = s;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (noise) begin
                bus.start = 1'($urandom);
                bus.a     = 8'($urandom);
                bus.b     = 8'($urandom);
                bus.cin   = 1'($urandom);
                bus.sub   = 1'($urandom);
            end
            tick();
            lat++;
            if (!bus.done) check_eq("busy_mid", {31'd0, bus.busy}, 32'd1);
        end
        bus.start = 1'b0;
        check_eq("latency", lat, W);
        check_eq("sum", {24'd0, bus.sum}, {24'd0, es});
        check_eq("cout", {31'd0, bus.cout}, {31'd0, ec});
        check_eq("ovf", {31'd0, bus.ovf}, {31'd0, eo});
        check_eq("ready_done", {31'd0, bus.ready}, 32'd1);
        check_quiet("fa_quiet_done");
    endtask

    initial begin
        logic [7:0] ca;
        logic [7:0] cb;
        logic       cc;
        logic       cs;
        logic [7:0] es;
        logic       ec;
        logic       eo;
        int         ndone;
        int         cyc;
        int         gap;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ready", {31'd0, bus.ready}, 32'd1);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_sum", {24'd0, bus.sum}, 32'd0);
        check_eq("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        check_quiet("rst_fa");

        // Directed cases
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("sum_held", {24'd0, bus.sum}, 32'h8D);
        check_eq("done_one_cycle", {31'd0, bus.done}, 32'd0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset during the fourth RUN cycle aborts the op with no done pulse
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h5C;
        bus.sub   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_ready", {31'd0, bus.ready}, 32'd1);
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_done", {31'd0, bus.done}, 32'd0);
        check_eq("abort_sum", {24'd0, bus.sum}, 32'd0);
        check_eq("abort_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        ndone = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);

        // Start held high: one result per WIDTH+1 cycles, starts during RUN ignored
        ca = 8'($urandom);
        cb = 8'($urandom);
        cc = 1'($urandom);
        cs = 1'b0;
        bus.start = 1'b1;
        bus.a     = ca;
        bus.b     = cb;
        bus.cin   = cc;
        bus.sub   = cs;
        tick();
        ndone = 0;
        cyc   = 0;
        for (int t = 0; t < 80 && ndone < 5; t++) begin
            tick();
            cyc++;
            if (bus.done) begin
                model(ca, cb, cc, cs, es, ec, eo);
                check_eq("b2b_gap", cyc, (ndone == 0) ? W : W + 1);
                check_eq("b2b_sum", {24'd0, bus.sum}, {24'd0, es});
                check_eq("b2b_flags", {30'd0, bus.cout, bus.ovf}, {30'd0, ec, eo});
                ndone++;
                cyc = 0;
                ca  = 8'($urandom);
                cb  = 8'($urandom);
                cc  = 1'($urandom);
                cs  = ~cs;
                bus.a     = ca;
                bus.b     = cb;
                bus.cin   = cc;
                bus.sub   = cs;
                bus.start = (ndone < 5);
            end else begin
                check_eq("b2b_busy", {31'd0, bus.busy}, 32'd1);
                bus.a   = 8'($urandom);
                bus.b   = 8'($urandom);
                bus.sub = 1'($urandom);
            end
        end
        check_eq("b2b_count", ndone, 5);
        bus.start = 1'b0;
        tick();
        check_eq("b2b_idle", {30'd0, bus.ready, bus.busy}, 32'd2);

        // Randomised add/sub with noise on the inputs while busy
        for (int n = 0; n < 2500; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check_quiet("fa_quiet_idle");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
